// File: rtl/rr_grant_arbiter.sv
// -----------------------------------------------------------------------------
// rr_grant_arbiter
//
// Round-robin arbiter that shares one downstream resource (for example one
// priority-encoder datapath slot) between WIDTH requesting clients.
// The winner is the lowest-index request at or above a rotating pointer.
// If no request is at or above the pointer, the lowest-index request anywhere
// wins. A grantee keeps the grant until it pulses release_i or drops its
// request. On that edge the next winner is registered with no idle bubble.
//
// Optional feature, selected by the macro RR_GRANT_HOLD_LIMIT_EN:
//   When the macro is defined, a grantee that has held the grant for MAX_HOLD
//   consecutive cycles is preempted, but only while another requester is
//   waiting. When the macro is undefined, the hold counter does not exist and
//   MAX_HOLD has no effect.
//
// Parameters:
//   WIDTH     number of requesters (>= 2)
//   MAX_HOLD  grant-cycle limit before forced preemption (>= 1)
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   srst_i       reset, asynchronous assert, active-high
//   req_i        per-requester request level               [WIDTH]
//   release_i    current grantee finishes this cycle
//   gnt_o        registered one-hot grant                   [WIDTH]
//   gnt_valid_o  high when gnt_o is nonzero
//   gnt_idx_o    binary index of the grantee, 0 if no grant [IDX_W]
//   busy_o       high while the arbiter is in GRANT
// -----------------------------------------------------------------------------
module rr_grant_arbiter #(
   parameter int WIDTH    = 5,
   parameter int MAX_HOLD = 8
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic [WIDTH-1:0]         req_i,
   input  logic                     release_i,
   output logic [WIDTH-1:0]         gnt_o,
   output logic                     gnt_valid_o,
   output logic [$clog2(WIDTH)-1:0] gnt_idx_o,
   output logic                     busy_o
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam bit PARAMS_OK = (WIDTH >= 2) && (MAX_HOLD >= 1);

   generate
      if (!PARAMS_OK) begin : g_bad_params
         $error("rr_grant_arbiter: WIDTH must be >= 2 and MAX_HOLD >= 1");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   mask_reg,  mask_next;
   logic [WIDTH-1:0]   gnt_reg,   gnt_next;
   logic [IDX_W-1:0]   idx_reg,   idx_next;

   logic [WIDTH-1:0]   above_k;     // bits strictly above the current grantee
   logic [WIDTH-1:0]   wrap_mask;   // pointer mask to install at end-of-grant
   logic [WIDTH-1:0]   arb_mask;
   logic [WIDTH-1:0]   masked_req;
   logic [WIDTH-1:0]   cand;
   logic [WIDTH-1:0]   pick;
   logic [IDX_W-1:0]   pick_idx;
   logic               grant_end;
   logic               preempt;

   // above_k[i] is set when the one-hot grant lies below bit i.
   // pick is the lowest set bit of cand.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
         if (gi == 0) begin : g_lsb
            assign above_k[gi] = 1'b0;
            assign pick[gi]    = cand[gi];
         end else begin : g_upper
            assign above_k[gi] = |gnt_reg[gi-1:0];
            assign pick[gi]    = cand[gi] & ~(|cand[gi-1:0]);
         end
      end
   endgenerate

   // When the top requester releases, the pointer wraps back to requester 0.
   assign wrap_mask = gnt_reg[WIDTH-1] ? {WIDTH{1'b1}} : above_k;

   // In IDLE, arbitration uses the stored pointer.
   // At end-of-grant, it uses the pointer being installed on the same edge.
   assign arb_mask   = (state_reg == ST_GRANT) ? wrap_mask : mask_reg;
   assign masked_req = req_i & arb_mask;
   assign cand       = (|masked_req) ? masked_req : req_i;

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pick[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
   end

`ifdef RR_GRANT_HOLD_LIMIT_EN
   localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

   // Preempt only when someone else is waiting.
   // A lone requester keeps the grant and the counter stays saturated.
   assign preempt = (state_reg == ST_GRANT) && (hold_cnt_reg == HOLD_LAST) &&
                    (|(req_i & ~gnt_reg));

   always_comb begin
      hold_cnt_next = hold_cnt_reg;
      if (state_reg != ST_GRANT || grant_end) begin
         hold_cnt_next = '0;
      end else if (hold_cnt_reg != HOLD_LAST) begin
         hold_cnt_next = hold_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         hold_cnt_reg <= '0;
      end else begin
         hold_cnt_reg <= hold_cnt_next;
      end
   end
`else
   assign preempt = 1'b0;
`endif

   // A release and a request drop on the same edge count as one end-of-grant.
   assign grant_end = (state_reg == ST_GRANT) &&
                      (release_i || !(|(req_i & gnt_reg)) || preempt);

   always_comb begin
      state_next = state_reg;
      mask_next  = mask_reg;
      gnt_next   = gnt_reg;
      idx_next   = idx_reg;
      case (state_reg)
         ST_IDLE: begin
            if (|req_i) begin
               gnt_next   = pick;
               idx_next   = pick_idx;
               state_next = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (grant_end) begin
               mask_next  = wrap_mask;
               gnt_next   = pick;
               idx_next   = pick_idx;
               // pick is zero only when no request remains at all.
               state_next = (|pick) ? ST_GRANT : ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            gnt_next   = '0;
            idx_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         state_reg <= ST_IDLE;
         mask_reg  <= {WIDTH{1'b1}};
         gnt_reg   <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         mask_reg  <= mask_next;
         gnt_reg   <= gnt_next;
         idx_reg   <= idx_next;
      end
   end

   assign gnt_o       = gnt_reg;
   assign gnt_valid_o = |gnt_reg;
   assign gnt_idx_o   = idx_reg;
   assign busy_o      = (state_reg == ST_GRANT);

endmodule
